sblk_row_ctrl: RTL and testbench

- Control front-end for a row of N_ROW superblocks.
- Takes one upstream instruction stream and buffers it per row in depth-parameterised FIFOs. Each instruction is targeted at one row or broadcast to all.
- Each queued instruction is issued to its superblock only when that superblock reports idle.
- Steers a tagged activation stream onto the per-row activation ports under the superblocks' request handshake.
- Serialises a masked snapshot of the wide psum bus into a tagged valid/ready word stream.

---
 rtl/sblk_row_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sblk_row_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sblk_row_ctrl.sv
// Row controller for N_ROW superblocks: per-row instruction queues with idle-gated issue,
// activation steering under the superblocks' request handshake, and tagged psum readout.
module sblk_row_ctrl #(
    parameter int N_ROW      = 6,
    parameter int N_COLUMN   = 5,
    parameter int WID_ACT    = 16,
    parameter int WID_PSUM   = 32,
    parameter int WID_INST   = 14,
    parameter int INST_DEPTH = 4,
    parameter int ISSUE_GAP  = 2,
    parameter int WID_ROW    = (N_ROW > 1) ? $clog2(N_ROW) : 1,
    parameter int WID_COL    = (N_COLUMN > 1) ? $clog2(N_COLUMN) : 1
) (
    input  logic                                  clk_l,
    input  logic                                  rst_n,
    input  logic [WID_INST-1:0]                   inst_in,
    input  logic [WID_ROW-1:0]                    inst_in_row,
    input  logic                                  inst_in_bcast,
    input  logic                                  inst_in_vld,
    output logic                                  inst_in_rdy,
    output logic [WID_INST*N_ROW-1:0]             inst_data,
    output logic [N_ROW-1:0]                      inst_en,
    input  logic [N_ROW-1:0]                      status_sblk,
    input  logic [2*WID_ACT-1:0]                  act_in,
    input  logic [WID_ROW-1:0]                    act_in_row,
    input  logic                                  act_in_bcast,
    input  logic                                  act_in_vld,
    output logic                                  act_in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]            act_data_in,
    output logic [N_ROW-1:0]                      act_data_in_vld,
    input  logic [N_ROW-1:0]                      act_data_in_req,
    input  logic [2*WID_PSUM*N_COLUMN*N_ROW-1:0]  psum_rd_data,
    input  logic                                  rd_start,
    input  logic [N_ROW-1:0]                      rd_mask,
    output logic [2*WID_PSUM-1:0]                 rd_data,
    output logic [WID_ROW-1:0]                    rd_row,
    output logic [WID_COL-1:0]                    rd_col,
    output logic                                  rd_vld,
    input  logic                                  rd_rdy,
    output logic                                  rd_busy,
    output logic                                  rd_done,
    output logic                                  all_idle
);
    localparam int AW = $clog2(INST_DEPTH);
    localparam int HW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam int WW = 2 * WID_PSUM;

    typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM, RD_DONE} rd_state_t;

    logic [WID_INST-1:0] fifo_mem [N_ROW][INST_DEPTH];
    logic [AW:0]         wr_ptr   [N_ROW];
    logic [AW:0]         rd_ptr   [N_ROW];
    logic [HW-1:0]       holdoff  [N_ROW];
    logic [N_ROW-1:0]    fifo_empty, fifo_full, issue, inst_sel, rdy_row, push, ho_active;
    logic [N_ROW-1:0]    act_sel;

    rd_state_t           rd_state;
    logic [N_ROW-1:0]    rd_left, rest_mask;
    logic [WID_ROW-1:0]  row_ptr;
    logic [WID_COL-1:0]  col_ptr;
    logic [WW-1:0]       snap [N_COLUMN];

    function automatic logic [WID_ROW-1:0] lowest_row(input logic [N_ROW-1:0] m);
        lowest_row = '0;
        for (int i = N_ROW - 1; i >= 0; i--) begin
            if (m[i]) lowest_row = WID_ROW'(i);
        end
    endfunction

    // A row whose head is issuing this cycle frees a slot, so it may accept even when full.
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        issue      = '0;
        inst_sel   = '0;
        rdy_row    = '0;
        ho_active  = '0;
        for (int r = 0; r < N_ROW; r++) begin
            fifo_empty[r] = (wr_ptr[r] == rd_ptr[r]);
            fifo_full[r]  = (wr_ptr[r][AW] != rd_ptr[r][AW]) &&
                            (wr_ptr[r][AW-1:0] == rd_ptr[r][AW-1:0]);
            ho_active[r]  = (holdoff[r] != '0);
            issue[r]      = !fifo_empty[r] && !status_sblk[r] && !ho_active[r];
            rdy_row[r]    = !fifo_full[r] || issue[r];
            inst_sel[r]   = inst_in_bcast || (inst_in_row == WID_ROW'(r));
        end
        inst_in_rdy = &(rdy_row | ~inst_sel);
        push        = {N_ROW{inst_in_vld && inst_in_rdy}} & inst_sel;
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            inst_en   <= '0;
            inst_data <= '0;
            for (int r = 0; r < N_ROW; r++) begin
                wr_ptr[r]  <= '0;
                rd_ptr[r]  <= '0;
                holdoff[r] <= '0;
            end
        end else begin
            inst_en <= issue;
            for (int r = 0; r < N_ROW; r++) begin
                if (issue[r]) begin
                    inst_data[r*WID_INST +: WID_INST] <= fifo_mem[r][rd_ptr[r][AW-1:0]];
                    rd_ptr[r]  <= rd_ptr[r] + 1'b1;
                    holdoff[r] <= HW'(ISSUE_GAP);
                end else if (ho_active[r]) begin
                    holdoff[r] <= holdoff[r] - 1'b1;
                end
                if (push[r]) wr_ptr[r] <= wr_ptr[r] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_l) begin
        for (int r = 0; r < N_ROW; r++) begin
            if (push[r]) fifo_mem[r][wr_ptr[r][AW-1:0]] <= inst_in;
        end
    end

    always_comb begin
        act_sel = '0;
        for (int r = 0; r < N_ROW; r++) begin
            act_sel[r] = act_in_bcast || (act_in_row == WID_ROW'(r));
        end
        act_in_rdy      = &(act_data_in_req | ~act_sel);
        act_data_in_vld = {N_ROW{act_in_vld && act_in_rdy}} & act_sel;
        act_data_in     = {N_ROW{act_in}};
    end

    always_comb begin
        rest_mask = rd_left & ~(N_ROW'(1) << row_ptr);
        rd_data   = '0;
        for (int c = 0; c < N_COLUMN; c++) begin
            if (col_ptr == WID_COL'(c)) rd_data = snap[c];
        end
    end

    assign rd_row   = row_ptr;
    assign rd_col   = col_ptr;
    assign all_idle = (&fifo_empty) && !(|status_sblk) && (rd_state == RD_IDLE) && !(|ho_active);

    // state     | meaning
    // RD_IDLE   | waiting for rd_start; rd_mask latched on start
    // RD_LOAD   | snapshot the current row's psum words
    // RD_STREAM | present snapshot words, advance on rd_vld & rd_rdy
    // RD_DONE   | one-cycle rd_done pulse
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_left  <= '0;
            row_ptr  <= '0;
            col_ptr  <= '0;
            rd_vld   <= 1'b0;
            rd_busy  <= 1'b0;
            rd_done  <= 1'b0;
            for (int c = 0; c < N_COLUMN; c++) snap[c] <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (rd_start) begin
                        rd_busy <= 1'b1;
                        if (rd_mask == '0) begin
                            rd_state <= RD_DONE;
                            rd_done  <= 1'b1;
                        end else begin
                            rd_left  <= rd_mask;
                            row_ptr  <= lowest_row(rd_mask);
                            rd_state <= RD_LOAD;
                        end
                    end
                end
                RD_LOAD: begin
                    for (int c = 0; c < N_COLUMN; c++) begin
                        snap[c] <= psum_rd_data[(int'(row_ptr)*N_COLUMN + c)*WW +: WW];
                    end
                    col_ptr  <= '0;
                    rd_vld   <= 1'b1;
                    rd_state <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (rd_rdy) begin
                        if (col_ptr == WID_COL'(N_COLUMN - 1)) begin
                            rd_vld <= 1'b0;
                            if (rest_mask != '0) begin
                                rd_left  <= rest_mask;
                                row_ptr  <= lowest_row(rest_mask);
                                rd_state <= RD_LOAD;
                            end else begin
                                rd_state <= RD_DONE;
                                rd_done  <= 1'b1;
                            end
                        end else begin
                            col_ptr <= col_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    rd_done  <= 1'b0;
                    rd_busy  <= 1'b0;
                    rd_state <= RD_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sblk_row_ctrl.sv
// Bench for sblk_row_ctrl: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_sblk_row_ctrl;
    localparam int N_ROW = 6, N_COLUMN = 5, WID_ACT = 16, WID_PSUM = 32, WID_INST = 14;
    localparam int INST_DEPTH = 4, ISSUE_GAP = 2, WID_ROW = 3, WID_COL = 3;
    localparam int WW = 2 * WID_PSUM, WA = 2 * WID_ACT;

    logic clk_l = 1'b0;
    logic rst_n = 1'b0;
    logic [WID_INST-1:0]         inst_in = '0;
    logic [WID_ROW-1:0]          inst_in_row = '0;
    logic                        inst_in_bcast = 1'b0, inst_in_vld = 1'b0, inst_in_rdy;
    logic [WID_INST*N_ROW-1:0]   inst_data;
    logic [N_ROW-1:0]            inst_en, status_sblk = '0;
    logic [WA-1:0]               act_in = '0;
    logic [WID_ROW-1:0]          act_in_row = '0;
    logic                        act_in_bcast = 1'b0, act_in_vld = 1'b0, act_in_rdy;
    logic [WA*N_ROW-1:0]         act_data_in;
    logic [N_ROW-1:0]            act_data_in_vld, act_data_in_req = '0;
    logic [WW*N_COLUMN*N_ROW-1:0] psum_rd_data;
    logic                        rd_start = 1'b0, rd_rdy = 1'b0;
    logic [N_ROW-1:0]            rd_mask = '0;
    logic [WW-1:0]               rd_data;
    logic [WID_ROW-1:0]          rd_row;
    logic [WID_COL-1:0]          rd_col;
    logic                        rd_vld, rd_busy, rd_done, all_idle;
    logic [WW-1:0]               psum_w [N_ROW][N_COLUMN];

    sblk_row_ctrl #(
        .N_ROW(N_ROW), .N_COLUMN(N_COLUMN), .WID_ACT(WID_ACT), .WID_PSUM(WID_PSUM),
        .WID_INST(WID_INST), .INST_DEPTH(INST_DEPTH), .ISSUE_GAP(ISSUE_GAP),
        .WID_ROW(WID_ROW), .WID_COL(WID_COL)
    ) dut (
        .clk_l(clk_l), .rst_n(rst_n), .inst_in(inst_in), .inst_in_row(inst_in_row),
        .inst_in_bcast(inst_in_bcast), .inst_in_vld(inst_in_vld), .inst_in_rdy(inst_in_rdy),
        .inst_data(inst_data), .inst_en(inst_en), .status_sblk(status_sblk),
        .act_in(act_in), .act_in_row(act_in_row), .act_in_bcast(act_in_bcast),
        .act_in_vld(act_in_vld), .act_in_rdy(act_in_rdy), .act_data_in(act_data_in),
        .act_data_in_vld(act_data_in_vld), .act_data_in_req(act_data_in_req),
        .psum_rd_data(psum_rd_data), .rd_start(rd_start), .rd_mask(rd_mask),
        .rd_data(rd_data), .rd_row(rd_row), .rd_col(rd_col), .rd_vld(rd_vld),
        .rd_rdy(rd_rdy), .rd_busy(rd_busy), .rd_done(rd_done), .all_idle(all_idle)
    );

    always #5 clk_l = ~clk_l;

    int n_vec = 0, n_err = 0, cyc = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] pat(input int r, input int c);
        return {16'hbeef, 8'(r), 8'(c), 16'h1234, 8'(r), 8'(c)};
    endfunction

    always_comb begin
        psum_rd_data = '0;
        for (int r = 0; r < N_ROW; r++)
            for (int c = 0; c < N_COLUMN; c++)
                psum_rd_data[(r*N_COLUMN + c)*WW +: WW] = psum_w[r][c];
    end

    // ---------------- reference model ----------------
    logic [WID_INST-1:0] m_q [N_ROW][INST_DEPTH];
    int                  m_n [N_ROW];
    int                  m_ho [N_ROW];
    logic [N_ROW-1:0]    m_en = '0, m_go;
    logic [WID_INST-1:0] m_data [N_ROW];
    bit                  m_load = 0, m_stream = 0, m_done = 0, m_acc;
    int                  m_row = 0, m_col = 0;
    int                  m_rows [$];
    logic [WW-1:0]       m_snap [N_COLUMN];

    function automatic bit m_ready(input int r);
        return m_n[r] > 0 && !status_sblk[r] && m_ho[r] == 0;
    endfunction

    function automatic bit m_inst_rdy();
        bit ok = 1'b1;
        for (int r = 0; r < N_ROW; r++)
            if ((inst_in_bcast || int'(inst_in_row) == r) && !(m_n[r] < INST_DEPTH || m_ready(r)))
                ok = 1'b0;
        return ok;
    endfunction

    function automatic bit m_act_rdy();
        bit ok = 1'b1;
        for (int r = 0; r < N_ROW; r++)
            if ((act_in_bcast || int'(act_in_row) == r) && !act_data_in_req[r]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [N_ROW-1:0] m_act_vld();
        logic [N_ROW-1:0] v = '0;
        for (int r = 0; r < N_ROW; r++)
            v[r] = act_in_vld && m_act_rdy() && (act_in_bcast || int'(act_in_row) == r);
        return v;
    endfunction

    function automatic bit m_all_idle();
        bit ok = !(m_load || m_stream || m_done) && status_sblk == '0;
        for (int r = 0; r < N_ROW; r++)
            if (m_n[r] != 0 || m_ho[r] != 0) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            m_en = '0; m_load = 0; m_stream = 0; m_done = 0; m_row = 0; m_col = 0;
            m_rows.delete();
            for (int r = 0; r < N_ROW; r++) begin m_n[r] = 0; m_ho[r] = 0; m_data[r] = '0; end
            for (int c = 0; c < N_COLUMN; c++) m_snap[c] = '0;
        end else begin
            m_acc = inst_in_vld && m_inst_rdy();
            for (int r = 0; r < N_ROW; r++) m_go[r] = m_ready(r);
            m_en = m_go;
            for (int r = 0; r < N_ROW; r++) begin
                if (m_go[r]) begin
                    m_data[r] = m_q[r][0];
                    for (int k = 0; k < INST_DEPTH - 1; k++) m_q[r][k] = m_q[r][k+1];
                    m_n[r]--;
                    m_ho[r] = ISSUE_GAP;
                end else if (m_ho[r] > 0) m_ho[r]--;
                if (m_acc && (inst_in_bcast || int'(inst_in_row) == r)) begin
                    m_q[r][m_n[r]] = inst_in;
                    m_n[r]++;
                end
            end
            if (m_done) m_done = 0;
            else if (m_load) begin
                for (int c = 0; c < N_COLUMN; c++) m_snap[c] = psum_w[m_row][c];
                m_col = 0; m_load = 0; m_stream = 1;
            end else if (m_stream) begin
                if (rd_rdy) begin
                    if (m_col == N_COLUMN - 1) begin
                        m_stream = 0;
                        if (m_rows.size() > 0) begin m_row = m_rows.pop_front(); m_load = 1; end
                        else m_done = 1;
                    end else m_col++;
                end
            end else if (rd_start) begin
                m_rows.delete();
                for (int r = 0; r < N_ROW; r++) if (rd_mask[r]) m_rows.push_back(r);
                if (m_rows.size() == 0) m_done = 1;
                else begin m_row = m_rows.pop_front(); m_load = 1; end
            end
        end
    end

    always @(posedge clk_l) cyc <= cyc + 1;

    // ---------------- per-cycle compare and event log ----------------
    int ev_row [$], ev_cyc [$];
    logic [WID_INST-1:0] ev_data [$];
    int got_row [$], got_col [$];
    logic [WW-1:0] got_data [$];
    int done_cnt = 0;

    always @(negedge clk_l) begin
        if (rst_n) begin
            chk("inst_in_rdy", inst_in_rdy, m_inst_rdy());
            chk("inst_en", inst_en, m_en);
            for (int r = 0; r < N_ROW; r++)
                chk("inst_data", inst_data[r*WID_INST +: WID_INST], m_data[r]);
            chk("act_in_rdy", act_in_rdy, m_act_rdy());
            chk("act_vld", act_data_in_vld, m_act_vld());
            chk("act_data", act_data_in, {N_ROW{act_in}});
            chk("rd_vld", rd_vld, m_stream);
            chk("rd_busy", rd_busy, m_load || m_stream || m_done);
            chk("rd_done", rd_done, m_done);
            chk("all_idle", all_idle, m_all_idle());
            if (m_stream) begin
                chk("rd_data", rd_data, m_snap[m_col]);
                chk("rd_row", rd_row, m_row);
                chk("rd_col", rd_col, m_col);
            end
            for (int r = 0; r < N_ROW; r++)
                if (inst_en[r]) begin
                    ev_row.push_back(r); ev_cyc.push_back(cyc);
                    ev_data.push_back(inst_data[r*WID_INST +: WID_INST]);
                end
            if (rd_vld && rd_rdy) begin
                got_row.push_back(int'(rd_row)); got_col.push_back(int'(rd_col));
                got_data.push_back(rd_data);
            end
            if (rd_done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_l); #1;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (!all_idle && k < 100) begin step(); k++; end
        chk(nm, all_idle, 1'b1);
    endtask

    task automatic clear_ev();
        ev_row.delete(); ev_cyc.delete(); ev_data.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k, n0;
        int rows_lit [3];
        bit trashed [N_ROW];
        logic [WID_INST-1:0] lit_t1 [3];
        rows_lit = '{0, 2, 5};
        lit_t1 = '{14'h011, 14'h022, 14'h033};
        for (int r = 0; r < N_ROW; r++)
            for (int c = 0; c < N_COLUMN; c++) psum_w[r][c] = pat(r, c);
        repeat (3) step();
        chk("rst_inst_en", inst_en, '0);
        chk("rst_inst_data", inst_data, '0);
        chk("rst_all_idle", all_idle, 1'b1);
        chk("rst_rd_busy", rd_busy, 1'b0);
        chk("rst_rd_vld", rd_vld, 1'b0);
        chk("rst_rd_done", rd_done, 1'b0);
        rst_n = 1'b1;
        step();

        // targeted issue to row 2
        clear_ev();
        inst_in_row = 3'd2; inst_in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin inst_in = lit_t1[i]; step(); end
        inst_in_vld = 1'b0;
        repeat (12) step();
        chk("t1_count", ev_row.size(), 3);
        for (int i = 0; i < 3 && i < ev_row.size(); i++) begin
            chk("t1_row", ev_row[i], 2);
            chk("t1_data", ev_data[i], lit_t1[i]);
            if (i > 0) chk("t1_gap", ev_cyc[i] - ev_cyc[i-1], ISSUE_GAP + 1);
        end

        // backpressure on row 0
        wait_idle("bp_idle");
        clear_ev();
        status_sblk = 6'b000001; inst_in_row = 3'd0; inst_in_vld = 1'b1;
        acc = 0; inst_in = 14'h100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_l);
            if (inst_in_rdy) acc++;
            step();
            inst_in = 14'h100 + 14'(acc);
        end
        chk("bp_accepts", acc, INST_DEPTH);
        @(negedge clk_l);
        chk("bp_rdy_full", inst_in_rdy, 1'b0);
        step();
        inst_in_bcast = 1'b1;
        @(negedge clk_l);
        chk("bp_bcast_stall", inst_in_rdy, 1'b0);
        step();
        inst_in_bcast = 1'b0; status_sblk = '0;
        #1 chk("bp_rdy_release", inst_in_rdy, 1'b1);
        step();
        inst_in_vld = 1'b0;
        repeat (20) step();
        n0 = 0;
        foreach (ev_row[i]) if (ev_row[i] == 0) n0++;
        chk("bp_row0_issues", n0, INST_DEPTH + 1);
        chk("bp_other_rows", ev_row.size(), INST_DEPTH + 1);

        // broadcast instruction
        wait_idle("bc_idle");
        inst_in = 14'h155; inst_in_bcast = 1'b1; inst_in_vld = 1'b1;
        step();
        inst_in_vld = 1'b0; inst_in_bcast = 1'b0;
        step();
        chk("bc_en", inst_en, 6'b111111);
        chk("bc_data", inst_data, {N_ROW{14'h155}});

        // activation steering
        act_data_in_req = 6'b101011; act_in = 32'hcafe_0001; act_in_vld = 1'b1;
        act_in_row = 3'd2;
        #1 chk("act_r2_rdy", act_in_rdy, 1'b0);
        chk("act_r2_vld", act_data_in_vld, '0);
        act_in_row = 3'd3;
        #1 chk("act_r3_vld", act_data_in_vld, 6'b001000);
        act_in_bcast = 1'b1;
        #1 chk("act_bc_rdy", act_in_rdy, 1'b0);
        step();
        act_data_in_req = 6'b111111;
        #1 chk("act_bc_rdy_all", act_in_rdy, 1'b1);
        chk("act_bc_vld", act_data_in_vld, 6'b111111);
        step();
        act_in_vld = 1'b0; act_in_bcast = 1'b0;

        // readout with a mid-row psum change and an ignored restart
        got_row.delete(); got_col.delete(); got_data.delete(); done_cnt = 0;
        foreach (trashed[r]) trashed[r] = 1'b0;
        rd_mask = 6'b100101; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 200) begin
            rd_rdy = 1'($urandom_range(0, 1));
            rd_start = (k == 4);
            if (got_row.size() > 0 && !trashed[got_row[got_row.size()-1]]) begin
                for (int c = 0; c < N_COLUMN; c++)
                    psum_w[got_row[got_row.size()-1]][c] = {$urandom, $urandom};
                trashed[got_row[got_row.size()-1]] = 1'b1;
            end
            step(); k++;
        end
        rd_start = 1'b0;
        chk("rd_finished", done_cnt > 0, 1'b1);
        repeat (4) step();
        chk("rd_words", got_row.size(), 15);
        for (int i = 0; i < 15 && i < got_row.size(); i++) begin
            chk("rd_tag_row", got_row[i], rows_lit[i/5]);
            chk("rd_tag_col", got_col[i], i % 5);
            chk("rd_word", got_data[i], pat(rows_lit[i/5], i % 5));
        end
        chk("rd_done_once", done_cnt, 1);
        for (int r = 0; r < N_ROW; r++)
            for (int c = 0; c < N_COLUMN; c++) psum_w[r][c] = pat(r, c);

        // empty mask
        got_row.delete(); rd_rdy = 1'b1; rd_mask = '0; rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("m0_done", rd_done, 1'b1);
        chk("m0_vld", rd_vld, 1'b0);
        step();
        chk("m0_done_end", rd_done, 1'b0);
        chk("m0_busy_end", rd_busy, 1'b0);
        chk("m0_no_words", got_row.size(), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            inst_in       = 14'($urandom);
            inst_in_row   = 3'($urandom_range(0, 7));
            inst_in_bcast = ($urandom_range(0, 7) == 0);
            inst_in_vld   = 1'($urandom);
            status_sblk   = 6'($urandom) & 6'($urandom);
            act_in        = $urandom;
            act_in_row    = 3'($urandom_range(0, 7));
            act_in_bcast  = ($urandom_range(0, 5) == 0);
            act_in_vld    = 1'($urandom);
            act_data_in_req = 6'($urandom) | 6'($urandom);
            rd_start      = ($urandom_range(0, 15) == 0);
            rd_mask       = 6'($urandom);
            rd_rdy        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0)
                psum_w[$urandom_range(0, N_ROW-1)][$urandom_range(0, N_COLUMN-1)] = {$urandom, $urandom};
            step();
        end
        inst_in_vld = 1'b0; act_in_vld = 1'b0; rd_start = 1'b0; rd_rdy = 1'b1;
        status_sblk = '0; inst_in_bcast = 1'b0;
        wait_idle("rand_drain");

        // reset during a stream with queued instructions
        status_sblk = 6'b111111; inst_in_row = 3'd1; inst_in_vld = 1'b1;
        repeat (2) step();
        inst_in_vld = 1'b0;
        rd_mask = 6'b111111; rd_start = 1'b1; rd_rdy = 1'b0;
        step();
        rd_start = 1'b0;
        k = 0;
        while (!rd_vld && k < 10) begin step(); k++; end
        chk("rs_streaming", rd_vld, 1'b1);
        clear_ev(); done_cnt = 0;
        @(posedge clk_l); #3;
        status_sblk = '0; rst_n = 1'b0;
        #1;
        chk("rs_rd_vld", rd_vld, 1'b0);
        chk("rs_rd_busy", rd_busy, 1'b0);
        chk("rs_all_idle", all_idle, 1'b1);
        chk("rs_inst_en", inst_en, '0);
        step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("rs_no_issue", ev_row.size(), 0);
        chk("rs_no_done", done_cnt, 0);
        chk("rs_idle_after", all_idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
